// File: rtl/mem_loader_pkg.sv
// Shared types for the program loader and memory-bus arbiter.
// Bus bundle types are reused by the mux; loader states use ST_ prefixes to avoid clashing with mw_t.
package mem_loader_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mw_t;

  typedef struct packed {
    mw_t   mw;
    addr_t addr;
    data_t data;
  } mem_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CSUM
  } loader_state_t;

  localparam data_t LOADER_SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/mem_bus_mux.sv
// 2:1 selector for the single memory port: loader bundle while the CPU is held, CPU otherwise.
module mem_bus_mux
  import mem_loader_pkg::*;
(
  input  logic     sel_loader,
  input  mem_req_t cpu_req,
  input  mem_req_t ldr_req,
  output mem_req_t mem_req
);

  assign mem_req = sel_loader ? ldr_req : cpu_req;

endmodule

// File: rtl/mem_loader.sv
// Framed byte-stream loader that owns the memory write port and holds the CPU off the bus mid-frame.
// Frame: SYNC, ADDR_HI, ADDR_LO, LEN (0 = 256), data bytes, CSUM (8-bit sum of all but SYNC is zero).
//
// state      | meaning
// ST_IDLE    | CPU owns the bus; hunting for SYNC_BYTE
// ST_ADDR_HI | waiting for load address high byte
// ST_ADDR_LO | waiting for load address low byte
// ST_LEN     | waiting for payload length
// ST_DATA    | waiting for next payload byte
// ST_WRITE   | single-cycle memory write of the captured byte
// ST_CSUM    | waiting for checksum byte
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter data_t       SYNC_BYTE      = LOADER_SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  data_t       rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  mw_t         cpu_mw,
  input  addr_t       cpu_addr,
  input  data_t       cpu_data,
  output mw_t         mem_mw,
  output addr_t       mem_addr,
  output data_t       mem_data,
  output logic        cpu_hold,
  output logic        load_ok,
  output logic        load_err,
  output logic [7:0]  frame_cnt
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  loader_state_t      state;
  mw_t                ldr_mw;
  addr_t              ldr_addr;
  data_t              ldr_data;
  addr_t              ptr;
  data_t              sum;
  logic [8:0]         remaining;
  logic [TIMER_W-1:0] timer;

  logic     accept;
  data_t    sum_next;
  mem_req_t cpu_req, ldr_req, mem_req;

  assign rx_ready = (state != ST_WRITE);
  assign cpu_hold = (state != ST_IDLE);
  assign accept   = rx_valid && rx_ready;
  assign sum_next = sum + rx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ldr_mw    <= READ;
      ldr_addr  <= '0;
      ldr_data  <= '0;
      ptr       <= '0;
      sum       <= '0;
      remaining <= '0;
      timer     <= '0;
      load_ok   <= 1'b0;
      load_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      load_ok  <= 1'b0;
      load_err <= 1'b0;

      if (state == ST_IDLE || accept) timer <= '0;
      else                            timer <= timer + 1'b1;

      // A stalled sender aborts the frame; whatever was already written stays in memory.
      if (state != ST_IDLE && !accept && timer == TIMER_LAST) begin
        load_err <= 1'b1;
        ldr_mw   <= READ;
        state    <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept && rx_data == SYNC_BYTE) state <= ST_ADDR_HI;
          end
          ST_ADDR_HI: begin
            if (accept) begin
              ptr[15:8] <= rx_data;
              sum       <= rx_data;
              state     <= ST_ADDR_LO;
            end
          end
          ST_ADDR_LO: begin
            if (accept) begin
              ptr[7:0] <= rx_data;
              sum      <= sum_next;
              state    <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (accept) begin
              remaining <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
              sum       <= sum_next;
              state     <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (accept) begin
              ldr_mw   <= WRITE;
              ldr_addr <= ptr;
              ldr_data <= rx_data;
              sum      <= sum_next;
              state    <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            ldr_mw    <= READ;
            ptr       <= ptr + 16'd1;
            remaining <= remaining - 9'd1;
            state     <= (remaining == 9'd1) ? ST_CSUM : ST_DATA;
          end
          ST_CSUM: begin
            if (accept) begin
              if (sum_next == 8'h00) begin
                load_ok   <= 1'b1;
                frame_cnt <= frame_cnt + 8'd1;
              end else begin
                load_err  <= 1'b1;
              end
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cpu_req = '{mw: cpu_mw, addr: cpu_addr, data: cpu_data};
  assign ldr_req = '{mw: ldr_mw, addr: ldr_addr, data: ldr_data};

  mem_bus_mux u_mux (
    .sel_loader (cpu_hold),
    .cpu_req    (cpu_req),
    .ldr_req    (ldr_req),
    .mem_req    (mem_req)
  );

  assign mem_mw   = mem_req.mw;
  assign mem_addr = mem_req.addr;
  assign mem_data = mem_req.data;

endmodule
